sccb_target: RTL and testbench

- SCCB/I2C-style responder that emulates the camera sensor end of the camera SCCB link.
- Decodes the device address, a 16-bit sub-address and data bytes from the link master.
- Holds a small byte register file and returns read data on the shared data line.
- Used as a bench/loopback stand-in for the sensor and as a fabric-side configuration shadow. Pairs with the SCCB master's sccb_clk_0 / sccb_data_out_0 / sccb_data_en_0.

---
 rtl/sccb_target.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sccb_target.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C-style responder that emulates the camera-sensor end of
// the SCCB link.
//
// It decodes the device address and a 16-bit sub-address, then either stores
// the data bytes that follow or returns read data from a small byte register
// file. It serves as a bench/loopback stand-in for the sensor and as a
// fabric-side configuration shadow. It pairs with the master's sccb_clk_0,
// sccb_data_out_0 and sccb_data_en_0.
//
// Ports
//   clk      system clock, at least 16x the SCCB bit rate
//   rstn     asynchronous active-low reset
//   scl_in   SCCB clock from the bus (asynchronous)
//   sda_in   SCCB data from the bus (asynchronous)
//   sda_out  value to drive when sda_oe is high; always 0
//   sda_oe   1 = pull sda low, 0 = release
//   wr_stb   one-cycle pulse per accepted in-window data byte
//   wr_addr  full sub-address of the write flagged by wr_stb
//   wr_data  data byte of the write flagged by wr_stb
//   busy     high from START until STOP or an abort to IDLE
//
// Build option
//   SCCB_TGT_AUTOINC_EN  when defined, the pointer advances after every
//                        written byte. When undefined, the pointer holds, so
//                        repeated write bytes land on the same register.
//
// State table
//   state    | meaning
//   IDLE     | bus idle, waiting for START
//   DEVADR   | shifting device address + R/W
//   ACK_DEV  | acking device address (9th clock)
//   SUB_HI   | shifting sub-address high byte
//   ACK_HI   | acking sub-address high byte
//   SUB_LO   | shifting sub-address low byte
//   ACK_LO   | acking sub-address low byte, pointer loaded
//   WDATA    | shifting a write data byte
//   ACK_WD   | acking a write data byte
//   RDATA    | driving a read byte MSB first
//   RD_NA    | sampling master ACK/NA after a read byte
//   IGNORE   | not addressed, waiting for START/STOP
module sccb_target #(
   parameter logic [6:0]  DEV_ADDR  = 7'h3C,
   parameter int          ADDR_BITS = 6,
   parameter logic [15:0] REG_BASE  = 16'h3000,
   parameter logic [7:0]  RST_VAL   = 8'h00
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_out,
   output logic        sda_oe,
   output logic        wr_stb,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        busy
);

   localparam int DEPTH = 1 << ADDR_BITS;

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_DEVADR  = 4'd1;
   localparam logic [3:0] S_ACK_DEV = 4'd2;
   localparam logic [3:0] S_SUB_HI  = 4'd3;
   localparam logic [3:0] S_ACK_HI  = 4'd4;
   localparam logic [3:0] S_SUB_LO  = 4'd5;
   localparam logic [3:0] S_ACK_LO  = 4'd6;
   localparam logic [3:0] S_WDATA   = 4'd7;
   localparam logic [3:0] S_ACK_WD  = 4'd8;
   localparam logic [3:0] S_RDATA   = 4'd9;
   localparam logic [3:0] S_RD_NA   = 4'd10;
   localparam logic [3:0] S_IGNORE  = 4'd11;

   logic       scl_m, scl_s, scl_h;
   logic       sda_m, sda_s, sda_h;
   logic [3:0] state;
   logic [3:0] bit_cnt;
   logic [6:0] rx;
   logic [6:0] tx;
   logic       rw;
   logic       na_ack;
   logic [7:0] addr_hi;
   logic [15:0] ptr;
   logic [7:0] mem [DEPTH];

   logic       start_c, stop_c, scl_rise, scl_fall, byte_done, in_win, mem_we;
   logic [7:0] new_byte, rd_byte;

   // Synchronisers and history reset to the idle-bus level (high), so leaving
   // reset cannot look like a bus edge.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scl_m <= 1'b1;
         scl_s <= 1'b1;
         scl_h <= 1'b1;
         sda_m <= 1'b1;
         sda_s <= 1'b1;
         sda_h <= 1'b1;
      end else begin
         scl_m <= scl_in;
         scl_s <= scl_m;
         scl_h <= scl_s;
         sda_m <= sda_in;
         sda_s <= sda_m;
         sda_h <= sda_s;
      end
   end

   assign start_c   = scl_s & scl_h & sda_h & ~sda_s;
   assign stop_c    = scl_s & scl_h & ~sda_h & sda_s;
   assign scl_rise  = scl_s & ~scl_h;
   assign scl_fall  = ~scl_s & scl_h;
   assign byte_done = scl_rise && (bit_cnt == 4'd7);
   assign new_byte  = {rx, sda_s};
   assign in_win    = (ptr[15:ADDR_BITS] == REG_BASE[15:ADDR_BITS]);
   assign rd_byte   = in_win ? mem[ptr[ADDR_BITS-1:0]] : 8'hFF;
   assign mem_we    = (state == S_WDATA) && byte_done && in_win && !start_c && !stop_c;

   assign sda_out = 1'b0;
   assign busy    = (state != S_IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
      end else if (mem_we) begin
         mem[ptr[ADDR_BITS-1:0]] <= new_byte;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= S_IDLE;
         bit_cnt <= 4'd0;
         rx      <= 7'd0;
         tx      <= 7'd0;
         rw      <= 1'b0;
         na_ack  <= 1'b0;
         addr_hi <= 8'd0;
         ptr     <= 16'd0;
         sda_oe  <= 1'b0;
         wr_stb  <= 1'b0;
         wr_addr <= 16'd0;
         wr_data <= 8'd0;
      end else begin
         wr_stb <= 1'b0;
         if (start_c) begin
            state   <= S_DEVADR;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
            na_ack  <= 1'b0;
         end else if (stop_c) begin
            state   <= S_IDLE;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
            na_ack  <= 1'b0;
         end else begin
            case (state)
               S_DEVADR, S_SUB_HI, S_SUB_LO, S_WDATA: begin
                  if (scl_rise) begin
                     rx      <= new_byte[6:0];
                     bit_cnt <= bit_cnt + 4'd1;
                     if (byte_done) begin
                        bit_cnt <= 4'd0;
                        case (state)
                           S_DEVADR: begin
                              if (new_byte[7:1] == DEV_ADDR) begin
                                 rw    <= new_byte[0];
                                 state <= S_ACK_DEV;
                              end else begin
                                 state <= S_IGNORE;
                              end
                           end
                           S_SUB_HI: begin
                              addr_hi <= new_byte;
                              state   <= S_ACK_HI;
                           end
                           S_SUB_LO: begin
                              ptr   <= {addr_hi, new_byte};
                              state <= S_ACK_LO;
                           end
                           default: begin
                              if (in_win) begin
                                 wr_stb  <= 1'b1;
                                 wr_addr <= ptr;
                                 wr_data <= new_byte;
                              end
`ifdef SCCB_TGT_AUTOINC_EN
                              ptr <= ptr + 16'd1;
`endif
                              state <= S_ACK_WD;
                           end
                        endcase
                     end
                  end
               end
               // First falling edge starts the ack, the second one ends the
               // 9th clock and hands over to the next phase.
               S_ACK_DEV, S_ACK_HI, S_ACK_LO, S_ACK_WD: begin
                  if (scl_fall) begin
                     if (!sda_oe) begin
                        sda_oe <= 1'b1;
                     end else begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                        case (state)
                           S_ACK_DEV: begin
                              if (rw) begin
                                 state  <= S_RDATA;
                                 sda_oe <= ~rd_byte[7];
                                 tx     <= rd_byte[6:0];
                              end else begin
                                 state <= S_SUB_HI;
                              end
                           end
                           S_ACK_HI: state <= S_SUB_LO;
                           default:  state <= S_WDATA;
                        endcase
                     end
                  end
               end
               // tx holds the bits not yet driven; bit_cnt counts the master's
               // sampling edges.
               S_RDATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_oe <= 1'b0;
                        na_ack <= 1'b0;
                        state  <= S_RD_NA;
                     end else begin
                        sda_oe <= ~tx[6];
                        tx     <= {tx[5:0], 1'b0};
                     end
                  end
               end
               S_RD_NA: begin
                  if (scl_rise) begin
                     if (sda_s) begin
                        state <= S_IDLE;
                     end else begin
                        ptr    <= ptr + 16'd1;
                        na_ack <= 1'b1;
                     end
                  end else if (scl_fall && na_ack) begin
                     na_ack  <= 1'b0;
                     bit_cnt <= 4'd0;
                     state   <= S_RDATA;
                     sda_oe  <= ~rd_byte[7];
                     tx      <= rd_byte[6:0];
                  end
               end
               S_IDLE, S_IGNORE: ;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: bus-level master for sccb_target. It keeps a register and
// pointer model of the target, and a queue of the writes that should appear
// on wr_stb.
`timescale 1ns/1ps
module tb_sccb_target;

   logic        clk = 1'b0;
   logic        rstn;
   logic        scl;
   logic        sda_m;
   logic        sda_in;
   logic        sda_out, sda_oe, wr_stb, busy;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;

   int errors = 0;
   int checks = 0;

   logic [7:0]  mdl_mem [64];
   logic [15:0] mdl_ptr;
   logic [23:0] exp_q [$];
   logic [7:0]  wbuf [$];
   logic        quiet = 1'b0;
   int          stb_cnt = 0;
   logic [15:0] last_wr_addr;
   logic [7:0]  last_wr_data;
   logic [7:0]  last_rd;

   assign sda_in = sda_m & ~sda_oe;

   sccb_target dut (
      .clk     (clk),
      .rstn    (rstn),
      .scl_in  (scl),
      .sda_in  (sda_in),
      .sda_out (sda_out),
      .sda_oe  (sda_oe),
      .wr_stb  (wr_stb),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #900us;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic logic mdl_in_win(input logic [15:0] p);
      return (p >= 16'h3000) && (p < 16'h3040);
   endfunction

   task automatic mdl_reset();
      for (int i = 0; i < 64; i++) mdl_mem[i] = 8'h00;
      mdl_ptr = 16'h0000;
   endtask

   // Per-cycle output checker.
   always @(negedge clk) begin
      if (rstn) begin
         if (sda_oe) chk("sda_out level", sda_out, 0);
         if (quiet) chk("sda_oe quiet", sda_oe, 0);
         if (wr_stb) begin
            stb_cnt++;
            last_wr_addr = wr_addr;
            last_wr_data = wr_data;
            if (exp_q.size() == 0) begin
               chk("unexpected wr_stb", 1, 0);
            end else begin
               logic [23:0] e;
               e = exp_q.pop_front();
               chk("wr_addr", wr_addr, e[23:8]);
               chk("wr_data", wr_data, e[7:0]);
            end
         end
      end
   end

   localparam int Q = 6;

   task automatic wq();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; wq();
      scl = 1'b1;   wq();
      sda_m = 1'b0; wq();
      scl = 1'b0;   wq();
   endtask

   task automatic bus_stop();
      scl = 1'b0;   sda_m = 1'b0; wq();
      scl = 1'b1;   wq();
      sda_m = 1'b1; wq();
   endtask

   task automatic write_bit(input logic b);
      sda_m = b; wq();
      scl = 1'b1; wq(); wq();
      scl = 1'b0; wq();
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; wq();
      scl = 1'b1; wq();
      b = sda_in; wq();
      scl = 1'b0; wq();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
      logic a;
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      read_bit(a);
      chk(nm, a, exp_ack ? 0 : 1);
   endtask

   task automatic do_write(input logic [15:0] sub);
      bus_start();
      chk("busy after start", busy, 1);
      send_byte(8'h78, 1'b1, "ack dev w");
      send_byte(sub[15:8], 1'b1, "ack sub hi");
      send_byte(sub[7:0], 1'b1, "ack sub lo");
      mdl_ptr = sub;
      foreach (wbuf[i]) begin
         if (mdl_in_win(mdl_ptr)) begin
            mdl_mem[mdl_ptr - 16'h3000] = wbuf[i];
            exp_q.push_back({mdl_ptr, wbuf[i]});
         end
`ifdef SCCB_TGT_AUTOINC_EN
         mdl_ptr = mdl_ptr + 16'd1;
`endif
         send_byte(wbuf[i], 1'b1, "ack wdata");
      end
      bus_stop();
      repeat (4) @(negedge clk);
      chk("busy after stop", busy, 0);
      chk("pending writes", exp_q.size(), 0);
      wbuf.delete();
   endtask

   task automatic do_read(input int n);
      logic [7:0] got, exp;
      logic b;
      bus_start();
      send_byte(8'h79, 1'b1, "ack dev r");
      for (int k = 0; k < n; k++) begin
         exp = mdl_in_win(mdl_ptr) ? mdl_mem[mdl_ptr - 16'h3000] : 8'hFF;
         for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            got[i] = b;
         end
         write_bit(k == n - 1);
         chk("read data", got, exp);
         last_rd = got;
         if (k != n - 1) mdl_ptr = mdl_ptr + 16'd1;
      end
      chk("sda_oe after NA", sda_oe, 0);
      bus_stop();
      repeat (4) @(negedge clk);
      chk("busy after read stop", busy, 0);
   endtask

   initial begin
      logic       b;
      int         s0;
      logic [15:0] sub;
      rstn = 1'b0; scl = 1'b1; sda_m = 1'b1;
      mdl_reset();
      repeat (3) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset sda_oe", sda_oe, 0);
      chk("reset wr_stb", wr_stb, 0);
      chk("reset wr_addr", wr_addr, 0);
      chk("reset wr_data", wr_data, 0);
      rstn = 1'b1;
      repeat (4) @(negedge clk);

      // Single in-window write.
      s0 = stb_cnt;
      wbuf.push_back(8'h5A);
      do_write(16'h3008);
      chk("stb count 3008", stb_cnt - s0, 1);
      chk("wr_addr literal", last_wr_addr, 16'h3008);
      chk("wr_data literal", last_wr_data, 8'h5A);

      // Two-phase read of the same register.
      do_write(16'h3008);
      do_read(1);
      chk("read 3008 literal", last_rd, 8'h5A);

      // Foreign device: no ack, no drive.
      quiet = 1'b1;
      bus_start();
      send_byte(8'h84, 1'b0, "no ack foreign");
      send_byte(8'h30, 1'b0, "no ack foreign 2");
      bus_stop();
      quiet = 1'b0;
      repeat (4) @(negedge clk);
      chk("busy after foreign", busy, 0);

      // Out-of-window write is acked but not stored.
      s0 = stb_cnt;
      wbuf.push_back(8'h11);
      do_write(16'h4000);
      chk("stb count 4000", stb_cnt - s0, 0);
      do_write(16'h4000);
      do_read(1);
      chk("read 4000 literal", last_rd, 8'hFF);

      // Window edge and pointer behaviour after write bytes.
      wbuf.push_back(8'hAA);
      wbuf.push_back(8'hBB);
      do_write(16'h303F);
      do_write(16'h303F);
      do_read(2);
      do_write(16'h303F);
      do_read(1);
`ifdef SCCB_TGT_AUTOINC_EN
      chk("read 303F literal", last_rd, 8'hAA);
`else
      chk("read 303F literal", last_rd, 8'hBB);
`endif

      // Pointer wrap on read-side increment.
      do_write(16'hFFFF);
      do_read(2);

      // Randomised writes and reads.
      for (int it = 0; it < 6; it++) begin
         if ($urandom_range(0, 3) == 0) sub = 16'h3040 + 16'($urandom_range(0, 255));
         else sub = 16'h3000 + 16'($urandom_range(0, 63));
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) wbuf.push_back(8'($urandom));
         do_write(sub);
         do_write(16'h3000 + 16'($urandom_range(0, 63)));
         do_read(int'($urandom_range(1, 3)));
      end

      // Reset while driving read bit 3.
      wbuf.push_back(8'hA5);
      do_write(16'h3010);
      do_write(16'h3010);
      bus_start();
      send_byte(8'h79, 1'b1, "ack dev r rst");
      for (int i = 0; i < 4; i++) read_bit(b);
      chk("drive bit3 low", sda_oe, 1);
      #3 rstn = 1'b0;
      #1;
      chk("sda_oe on reset", sda_oe, 0);
      chk("busy on reset", busy, 0);
      chk("wr_addr on reset", wr_addr, 0);
      mdl_reset();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      sda_m = 1'b1; scl = 1'b1;
      wq(); wq();

      // Restart after reset; every register back to RST_VAL.
      do_write(16'h3000);
      do_read(64);

      chk("final pending writes", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
